// File: rtl/bet_entry.sv
// bet_entry: wager entry FSM that takes a bet type and amount from the switches
// and locks them for the settling logic until the round is done.
module bet_entry #(
   parameter logic [7:0] MIN_BET = 8'd1,
   parameter logic [7:0] MAX_BET = 8'd255
) (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       key_enter,
   input  logic       key_cancel,
   input  logic [1:0] bet_type_sw,
   input  logic [7:0] bet_amount_sw,
   input  logic [7:0] current_balance,
   input  logic       round_done,
   output logic [1:0] currentbettype,
   output logic [7:0] currentbetamount,
   output logic       bet_valid,
   output logic       bet_error,
   output logic [1:0] entry_state
);
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      GET_TYPE   = 2'b01,
      GET_AMOUNT = 2'b10,
      ARMED      = 2'b11
   } state_t;
   state_t     state;
   logic       init, enter_r, enter_d, cancel_r, cancel_d;
   logic [1:0] stage;
   logic       enter_ev, cancel_ev, amount_ok;
   assign enter_ev    = enter_r & ~enter_d;
   assign cancel_ev   = cancel_r & ~cancel_d;
   assign amount_ok   = bet_amount_sw >= MIN_BET && bet_amount_sw <= MAX_BET &&
                        bet_amount_sw <= current_balance;
   assign entry_state = state;
   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         state            <= IDLE;
         init             <= 1'b1;
         enter_r          <= 1'b0;
         enter_d          <= 1'b0;
         cancel_r         <= 1'b0;
         cancel_d         <= 1'b0;
         stage            <= 2'b00;
         currentbettype   <= 2'b00;
         currentbetamount <= 8'd0;
         bet_valid        <= 1'b0;
         bet_error        <= 1'b0;
      end else begin
         init     <= 1'b0;
         enter_r  <= key_enter;
         cancel_r <= key_cancel;
         // First edge after reset primes both stages so a held key makes no event
         enter_d  <= init ? key_enter : enter_r;
         cancel_d <= init ? key_cancel : cancel_r;
         bet_error <= 1'b0;
         case (state)
            IDLE: begin
               if (enter_ev) begin
                  if (current_balance >= MIN_BET) state <= GET_TYPE;
                  else bet_error <= 1'b1;
               end
            end
            GET_TYPE: begin
               if (cancel_ev) begin
                  state <= IDLE;
                  stage <= 2'b00;
               end else if (enter_ev) begin
                  if (bet_type_sw != 2'b00) begin
                     stage <= bet_type_sw;
                     state <= GET_AMOUNT;
                  end else bet_error <= 1'b1;
               end
            end
            GET_AMOUNT: begin
               if (cancel_ev) begin
                  state <= IDLE;
                  stage <= 2'b00;
               end else if (enter_ev) begin
                  if (amount_ok) begin
                     currentbettype   <= stage;
                     currentbetamount <= bet_amount_sw;
                     bet_valid        <= 1'b1;
                     state            <= ARMED;
                  end else bet_error <= 1'b1;
               end
            end
            ARMED: begin
               if (round_done) begin
                  bet_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bet_entry.sv
// tb_bet_entry: directed and random checks of bet_entry against a behavioural model.
module tb_bet_entry;
   localparam logic [7:0] MINB = 8'd2;
   localparam logic [7:0] MAXB = 8'd200;
   localparam logic [1:0] S_IDLE = 2'd0, S_TYPE = 2'd1, S_AMT = 2'd2, S_ARM = 2'd3;

   logic       clk = 1'b0;
   logic       rb = 1'b0, ke = 1'b0, kc = 1'b0, rd = 1'b0;
   logic [1:0] bt = 2'b00;
   logic [7:0] ba = 8'd0, bal = 8'd0;
   logic [1:0] currentbettype, entry_state;
   logic [7:0] currentbetamount;
   logic       bet_valid, bet_error;

   bet_entry #(.MIN_BET(MINB), .MAX_BET(MAXB)) dut (
      .slow_clock(clk), .resetb(rb), .key_enter(ke), .key_cancel(kc),
      .bet_type_sw(bt), .bet_amount_sw(ba), .current_balance(bal), .round_done(rd),
      .currentbettype(currentbettype), .currentbetamount(currentbetamount),
      .bet_valid(bet_valid), .bet_error(bet_error), .entry_state(entry_state)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_bad = 0, err_seen = 0;

   // Model: a press counts when the key was seen high at the previous edge and
   // low at the one before, counting only edges since reset was released.
   logic ke_hist[$], kc_hist[$];
   logic [1:0] ms, mtype, mstage;
   logic [7:0] mamt;
   logic       mvalid, merr;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic ev_e, ev_c;
      int n;
      if (!rb) begin
         ms = S_IDLE; mtype = 0; mamt = 0; mvalid = 0; merr = 0; mstage = 0;
         ke_hist.delete(); kc_hist.delete();
      end else begin
         n = ke_hist.size();
         ev_e = n >= 2 && ke_hist[n-1] && !ke_hist[n-2];
         ev_c = n >= 2 && kc_hist[n-1] && !kc_hist[n-2];
         ke_hist.push_back(ke); kc_hist.push_back(kc);
         if (ke_hist.size() > 2) begin
            void'(ke_hist.pop_front()); void'(kc_hist.pop_front());
         end
         merr = 0;
         if (ms == S_IDLE) begin
            if (ev_e) begin
               if (bal >= MINB) ms = S_TYPE; else merr = 1;
            end
         end else if (ms == S_TYPE || ms == S_AMT) begin
            if (ev_c) begin
               ms = S_IDLE; mstage = 0;
            end else if (ev_e && ms == S_TYPE) begin
               if (bt != 0) begin mstage = bt; ms = S_AMT; end else merr = 1;
            end else if (ev_e) begin
               if (ba >= MINB && ba <= MAXB && ba <= bal) begin
                  mtype = mstage; mamt = ba; mvalid = 1; ms = S_ARM;
               end else merr = 1;
            end
         end else if (rd) begin
            mvalid = 0; ms = S_IDLE;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (bet_error) err_seen++;
      chk("entry_state", entry_state, ms);
      chk("bet_valid", bet_valid, mvalid);
      chk("bet_error", bet_error, merr);
      chk("currentbettype", currentbettype, mtype);
      chk("currentbetamount", currentbetamount, mamt);
   endtask

   task automatic press_enter();
      err_seen = 0;
      ke = 1; step(); step();
      ke = 0; step(); step();
   endtask

   task automatic press_cancel();
      kc = 1; step(); step();
      kc = 0; step(); step();
   endtask

   task automatic pulse_done();
      rd = 1; step();
      rd = 0; step();
   endtask

   initial begin
      rb = 0; step(); step();
      chk("reset_state", entry_state, 2'd0);
      chk("reset_valid", bet_valid, 1'b0);
      rb = 1; bal = 100; step(); step();
      // Normal bet with latency check
      press_enter();
      chk("r034_get_type", entry_state, 2'd1);
      bt = 2'b10; press_enter();
      chk("r034_get_amount", entry_state, 2'd2);
      ba = 40;
      ke = 1; step();
      chk("r023_valid_early", bet_valid, 1'b0);
      step();
      chk("r023_valid_on_time", bet_valid, 1'b1);
      ke = 0; step(); step();
      chk("r034_type", currentbettype, 2'b10);
      chk("r034_amount", currentbetamount, 8'd40);
      chk("r034_state", entry_state, 2'd3);
      // Balance change and keys in ARMED do nothing
      bal = 5; ba = 7; press_enter(); press_cancel();
      chk("r026_state", entry_state, 2'd3);
      chk("r030_amount", currentbetamount, 8'd40);
      pulse_done();
      chk("r037_valid", bet_valid, 1'b0);
      chk("r037_state", entry_state, 2'd0);
      chk("r037_amount_kept", currentbetamount, 8'd40);
      // Illegal type and zero amount
      bal = 100; press_enter();
      bt = 2'b00; press_enter();
      chk("r036_type_err", err_seen, 1);
      chk("r036_stay_type", entry_state, 2'd1);
      bt = 2'b01; press_enter();
      ba = 0; press_enter();
      chk("r036_amt_err", err_seen, 1);
      chk("r036_stay_amt", entry_state, 2'd2);
      press_cancel();
      chk("r024_cancel", entry_state, 2'd0);
      // Over-balance then exact balance
      bal = 30; press_enter();
      bt = 2'b11; press_enter();
      ba = 31; press_enter();
      chk("r035_over_err", err_seen, 1);
      chk("r035_stay_amt", entry_state, 2'd2);
      ba = 30; press_enter();
      chk("r035_amount", currentbetamount, 8'd30);
      chk("r035_valid", bet_valid, 1'b1);
      // Done and enter together in ARMED drops the enter
      ke = 1; step(); rd = 1; step(); rd = 0; ke = 0; step(); step();
      chk("r029_idle", entry_state, 2'd0);
      // Over MAX_BET and below MIN_BET, balance below MIN_BET
      bal = 255; press_enter(); bt = 2'b01; press_enter();
      ba = 201; press_enter();
      chk("max_err", err_seen, 1);
      ba = 1; press_enter();
      chk("min_err", err_seen, 1);
      ba = 200; press_enter();
      chk("max_ok", currentbetamount, 8'd200);
      pulse_done();
      bal = 1; press_enter();
      chk("low_bal_err", err_seen, 1);
      chk("low_bal_idle", entry_state, 2'd0);
      // Simultaneous enter and cancel in GET_AMOUNT
      bal = 100; press_enter(); bt = 2'b10; press_enter();
      ke = 1; kc = 1; step(); step(); ke = 0; kc = 0; step(); step();
      chk("r025_priority", entry_state, 2'd0);
      // Reset mid-entry with enter held through release
      press_enter(); bt = 2'b01; press_enter();
      ke = 1; rb = 0; step();
      rb = 1; step(); step(); step(); step();
      chk("r033_no_edge", entry_state, 2'd0);
      chk("r032_amount", currentbetamount, 8'd0);
      ke = 0; step(); step();
      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) ke = ~ke;
         if ($urandom_range(11) == 0) kc = ~kc;
         bt = 2'($urandom_range(3));
         ba = $urandom_range(3) == 0 ? 8'($urandom_range(4)) : 8'($urandom);
         if ($urandom_range(7) == 0) bal = 8'($urandom);
         rd = $urandom_range(9) == 0;
         rb = $urandom_range(150) != 0;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
